// File: rtl/pending_reg_encoder.sv
// Sequential register-mask encoder: captures a multi-hot mask and emits the
// index of each set bit, lowest first, one per valid/ready handshake.
module pending_reg_encoder #(
   parameter int N = 32,
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] mask_in,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_idx,
   output logic         done,
   output logic [N-1:0] pending,
   output logic         state_dbg
);

   // Handshake: an index transfers on any rising clk where out_valid and
   // out_ready are both high; out_idx is stable while out_valid waits on ready.
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

   state_t       state, state_nxt;
   logic [N-1:0] pending_nxt;
   logic         done_nxt;
   logic [W-1:0] lowest;
   logic [N-1:0] clr;

   always_comb begin
      lowest = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) lowest = W'(i);
      end
   end

   always_comb begin
      clr = '0;
      clr[lowest] = 1'b1;
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      done_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               if (mask_in != '0) begin
                  pending_nxt = mask_in;
                  state_nxt   = DRAIN;
               end else begin
                  // An empty capture completes immediately.
                  done_nxt = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (out_ready) begin
               pending_nxt = pending & ~clr;
               if (pending_nxt == '0) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pending <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         done    <= done_nxt;
      end
   end

   assign busy      = (state == DRAIN);
   assign out_valid = (state == DRAIN);
   assign out_idx   = (state == DRAIN) ? lowest : '0;
   assign state_dbg = state;

endmodule

// File: tb/tb_pending_reg_encoder.sv
// Directed bench for pending_reg_encoder: expected indices and done pulses are
// queued by the stimulus and consumed by an independent output monitor.
module tb_pending_reg_encoder;

   localparam int N = 32;
   localparam int W = 5;

   logic         clk;
   logic         reset;
   logic         load;
   logic [N-1:0] mask_in;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_idx;
   logic         done;
   logic [N-1:0] pending;
   logic         state_dbg;

   logic [W-1:0] exp_q[$];
   int           exp_done;
   int           n_cmp;
   int           n_err;
   logic         mon_en;

   pending_reg_encoder #(.N(N), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .mask_in   (mask_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .done      (done),
      .pending   (pending),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // driver: advance one cycle, inputs change 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) exp_q.push_back(W'(i));
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL mon_idx: unexpected index %0d, none expected at %0t", out_idx, $time);
            end else begin
               logic [W-1:0] e;
               e = exp_q.pop_front();
               if (out_idx !== e) begin
                  n_err++;
                  $display("FAIL mon_idx: got %0d expected %0d at %0t", out_idx, e, $time);
               end
            end
         end
         if (done === 1'b1) begin
            n_cmp++;
            if (exp_done <= 0) begin
               n_err++;
               $display("FAIL mon_done: unexpected done pulse at %0t", $time);
            end else begin
               exp_done--;
            end
            if (out_valid !== 1'b0) begin
               n_err++;
               $display("FAIL mon_done_valid: done with out_valid=%b at %0t", out_valid, $time);
            end
         end
      end
   end

   initial begin
      n_cmp = 0; n_err = 0; exp_done = 0; mon_en = 1'b0;
      reset = 1'b1; load = 1'b1; mask_in = 32'hFFFF_FFFF; out_ready = 1'b0;

      // 1: reset with load asserted
      step(); step();
      check("rst_busy", N'(busy), N'(0));
      check("rst_valid", N'(out_valid), N'(0));
      check("rst_idx", N'(out_idx), N'(0));
      check("rst_done", N'(done), N'(0));
      check("rst_pending", pending, '0);
      check("rst_state", N'(state_dbg), N'(0));
      reset = 1'b0; load = 1'b0; mask_in = '0;
      mon_en = 1'b1;
      step();

      // 2: two-bit mask, ready high
      exp_q.push_back(W'(0)); exp_q.push_back(W'(2)); exp_done++;
      load = 1'b1; mask_in = 32'h0000_0005; out_ready = 1'b1;
      step(); load = 1'b0;
      check("t2_idx0", N'(out_idx), N'(0));
      check("t2_busy", N'(busy), N'(1));
      step();
      check("t2_idx2", N'(out_idx), N'(2));
      step();
      check("t2_done", N'(done), N'(1));
      check("t2_valid", N'(out_valid), N'(0));
      check("t2_pending", pending, '0);
      step();
      check("t2_done_pulse", N'(done), N'(0));

      // 3: backpressure then drain, includes top bit
      exp_q.push_back(W'(4)); exp_q.push_back(W'(31)); exp_done++;
      load = 1'b1; mask_in = 32'h8000_0010; out_ready = 1'b0;
      step(); load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t3_hold_idx", N'(out_idx), N'(4));
         check("t3_hold_pending", pending, 32'h8000_0010);
         if (i < 2) step();
      end
      out_ready = 1'b1;
      step();
      check("t3_idx31", N'(out_idx), N'(31));
      check("t3_pending31", pending, 32'h8000_0000);
      step();
      check("t3_done", N'(done), N'(1));
      step();

      // 4: empty mask, then full mask
      exp_done++;
      load = 1'b1; mask_in = '0;
      step(); load = 1'b0;
      check("t4_zero_done", N'(done), N'(1));
      check("t4_zero_valid", N'(out_valid), N'(0));
      step();
      check("t4_zero_done_pulse", N'(done), N'(0));
      check("t4_zero_valid2", N'(out_valid), N'(0));
      push_range(0, 31); exp_done++;
      load = 1'b1; mask_in = 32'hFFFF_FFFF;
      step(); load = 1'b0;
      for (int i = 0; i < 32; i++) begin
         check("t4_full_idx", N'(out_idx), N'(i));
         step();
      end
      check("t4_full_done", N'(done), N'(1));
      check("t4_full_valid", N'(out_valid), N'(0));
      step();

      // 5: load ignored while busy; load accepted on the done cycle
      push_range(4, 7); exp_done++;
      load = 1'b1; mask_in = 32'h0000_00F0;
      step(); load = 1'b0;
      check("t5_idx4", N'(out_idx), N'(4));
      load = 1'b1; mask_in = 32'h0000_0001;
      step(); load = 1'b0;
      check("t5_idx5", N'(out_idx), N'(5));
      check("t5_pending", pending, 32'h0000_00E0);
      step();
      check("t5_idx6", N'(out_idx), N'(6));
      step();
      check("t5_idx7", N'(out_idx), N'(7));
      step();
      check("t5_done", N'(done), N'(1));
      exp_q.push_back(W'(1)); exp_done++;
      load = 1'b1; mask_in = 32'h0000_0002;
      step(); load = 1'b0;
      check("t5_reload_idx", N'(out_idx), N'(1));
      check("t5_reload_valid", N'(out_valid), N'(1));
      check("t5_reload_done", N'(done), N'(0));
      step();
      check("t5_reload_finish", N'(done), N'(1));
      step();

      // 6: reset mid-drain discards the mask without a done pulse
      exp_q.push_back(W'(8)); exp_q.push_back(W'(9));
      load = 1'b1; mask_in = 32'h0000_0F00;
      step(); load = 1'b0;
      check("t6_idx8", N'(out_idx), N'(8));
      step();
      check("t6_idx9", N'(out_idx), N'(9));
      step();
      check("t6_idx10", N'(out_idx), N'(10));
      reset = 1'b1; out_ready = 1'b0;
      step();
      check("t6_pending", pending, '0);
      check("t6_valid", N'(out_valid), N'(0));
      check("t6_busy", N'(busy), N'(0));
      check("t6_done", N'(done), N'(0));
      reset = 1'b0;
      step();
      check("t6_done_after", N'(done), N'(0));
      step(); step();

      check("end_idx_queue_empty", N'(exp_q.size()), N'(0));
      check("end_done_all_seen", N'(exp_done), N'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
